// File: rtl/axis_dsm_dac_ctrl.sv
// -----------------------------------------------------------------------------
// axis_dsm_dac_ctrl
//
// Sample-rate scheduler and soft-mute controller at the front of the DAC chain
// (source -> this block -> comb -> zoh -> integrator -> DSM). It opens one
// sample slot every R clocks. On each slot it pulls a source sample, scales it
// by a ramped gain and emits it to the comb stage. When the source has nothing
// to offer, it holds the last sample. Ramping the gain on start and stop keeps
// the analog output free of pops.
//
// Optional feature:
//   DSM_CTRL_UNDERFLOW_CNT_EN  when defined, underflow_cnt is a saturating
//                              count of non-idle slots that found the source
//                              empty; when undefined, it is tied to 0.
//
// Ports:
//   aclk, arst_n        clock, asynchronous active-low reset
//   enable              1 = play, 0 = ramp to mute and stop (sampled on slots)
//   s_axis_data_*       source stream; tready pulses on consuming slot cycles
//   m_axis_data_*       gained sample to comb; tvalid is a one-cycle pulse
//                       per slot, tdata holds between pulses
//   dsm_en              high while the controller is not idle
//   busy                high while ramping up or down
//   underflow_cnt       saturating empty-slot count (see macro above)
// -----------------------------------------------------------------------------
module axis_dsm_dac_ctrl #(
  parameter int WIDTH      = 16,
  parameter int R          = 100,
  parameter int RAMP_SHIFT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 arst_n,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  output logic [WIDTH-1:0]     m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  output logic                 dsm_en,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] underflow_cnt
);

  localparam int SW = (R > 1) ? $clog2(R) : 1;
  localparam int GW = RAMP_SHIFT + 1;
  // Product width: signed sample times a non-negative gain with a sign bit.
  localparam int PW = WIDTH + GW + 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(R - 1);
  localparam logic [GW-1:0] GAIN_MAX  = GW'(2 ** RAMP_SHIFT);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t            state, state_next;
  logic [SW-1:0]     slot_cnt;
  logic [GW-1:0]     gain, gain_next;
  logic [WIDTH-1:0]  held, held_next;
  logic              slot;
  logic signed [PW-1:0] sample_ext, gain_ext, product;

  assign slot               = (slot_cnt == SLOT_LAST);
  assign s_axis_data_tready = slot && (state != IDLE);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    gain_next  = gain;
    held_next  = held;
    if (slot) begin
      // Idle slots flush the held sample; active slots take the source sample
      // if offered, otherwise keep repeating the last one.
      if (state == IDLE)           held_next = '0;
      else if (s_axis_data_tvalid) held_next = s_axis_data_tdata;

      unique case (state)
        IDLE: begin
          if (enable) state_next = RAMP_UP;
        end
        RAMP_UP: begin
          // A stop request reverses the ramp from the current gain.
          if (!enable) begin
            state_next = RAMP_DOWN;
          end else if (gain == GAIN_MAX) begin
            state_next = RUN;
          end else begin
            gain_next = gain + GW'(1);
            if (gain_next == GAIN_MAX) state_next = RUN;
          end
        end
        RUN: begin
          if (!enable) state_next = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (enable) begin
            state_next = RAMP_UP;
          end else if (gain == '0) begin
            state_next = IDLE;
          end else begin
            gain_next = gain - GW'(1);
            if (gain_next == '0) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // The slot output uses the gain from before this slot's update, applied to
  // the sample captured on this slot.
  assign sample_ext = PW'($signed(held_next));
  assign gain_ext   = PW'({1'b0, gain});
  assign product    = sample_ext * gain_ext;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      slot_cnt           <= '0;
      state              <= IDLE;
      gain               <= '0;
      held               <= '0;
      m_axis_data_tdata  <= '0;
      m_axis_data_tvalid <= 1'b0;
      dsm_en             <= 1'b0;
      busy               <= 1'b0;
    end else begin
      slot_cnt           <= slot ? '0 : slot_cnt + SW'(1);
      state              <= state_next;
      gain               <= gain_next;
      held               <= held_next;
      m_axis_data_tvalid <= slot;
      if (slot) m_axis_data_tdata <= WIDTH'(product >>> RAMP_SHIFT);
      // Flags follow the state being entered so they line up with the pulse.
      dsm_en <= (state_next != IDLE);
      busy   <= (state_next == RAMP_UP) || (state_next == RAMP_DOWN);
    end
  end

`ifdef DSM_CTRL_UNDERFLOW_CNT_EN
  logic [CNT_WIDTH-1:0] uf_cnt;

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      uf_cnt <= '0;
    end else if (s_axis_data_tready && !s_axis_data_tvalid && (uf_cnt != '1)) begin
      uf_cnt <= uf_cnt + CNT_WIDTH'(1);
    end
  end

  assign underflow_cnt = uf_cnt;
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: doc/axis_dsm_dac_ctrl.md
Name: axis_dsm_dac_ctrl

Overview:
Sample-rate scheduler and soft-mute controller at the front of the DAC chain: sine/stream source -> this block -> axis_comb -> axis_zoh -> axis_integrator -> DSM.
- Pulls one input sample every R clocks and applies a linear gain ramp on start/stop to avoid pops.
- Keeps the CIC fed with a sample every R clocks, including zeros when idle.
- Raises dsm_en for the DSM stage and holds the last sample on source underflow.

Parameters:
WIDTH, 16, signed sample width in and out
R, 100, interpolation ratio; one sample slot every R aclk cycles (R >= 2)
RAMP_SHIFT, 4, gain resolution; ramp spans 2^RAMP_SHIFT slots
CNT_WIDTH, 16, underflow counter width

Ports:
aclk  in  1  clock
arst_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = play, 0 = mute and stop
s_axis_data_tdata  in  WIDTH  signed source sample
s_axis_data_tvalid  in  1  source sample valid
s_axis_data_tready  out  1  pulses for exactly the slot cycle while consuming
m_axis_data_tdata  out  WIDTH  signed gained sample to comb; no backpressure
m_axis_data_tvalid  out  1  one-cycle pulse per slot
dsm_en  out  1  DSM enable; high when not IDLE
busy  out  1  high in RAMP_UP, RAMP_DOWN
underflow_cnt  out  CNT_WIDTH  saturating count of empty slots

Behaviour:
- Reset: slot counter 0, state IDLE, gain 0, held sample 0. All outputs 0.
- Slot counter: 0..R-1, wraps. A slot cycle occurs when the counter equals R-1. The counter runs in every state, so slot timing is continuous.
- States: IDLE, RAMP_UP, RUN, RAMP_DOWN. Transitions are evaluated only on slot cycles.
  - IDLE: enable=1 -> RAMP_UP.
  - RAMP_UP: gain += 1 per slot. Gain reaching 2^RAMP_SHIFT -> RUN. enable=0 -> RAMP_DOWN from the current gain.
  - RUN: enable=0 -> RAMP_DOWN.
  - RAMP_DOWN: gain -= 1 per slot. Gain reaching 0 -> IDLE. enable=1 -> RAMP_UP from the current gain.
- Gain: unsigned, RAMP_SHIFT+1 bits, range 0..2^RAMP_SHIFT. The slot output uses the gain value from before that slot's update.
- s_axis_data_tready = slot cycle AND state != IDLE. It is combinational from the counter/state only and never depends on tvalid.
- Sample capture on a non-IDLE slot:
  - tvalid=1: capture tdata into the held sample.
  - tvalid=0: keep the held sample; underflow_cnt += 1, saturating at all-ones.
- IDLE slots: held sample cleared to 0, no underflow counted.
- Output:
  - m_tdata = (held_sample * gain) >>> RAMP_SHIFT. Signed multiply at full width, arithmetic shift, truncate to WIDTH; no overflow is possible.
  - Output is registered: m_tvalid is high on the cycle after each slot cycle, including IDLE slots (tdata 0).
  - m_tdata holds its value between pulses.
- dsm_en and busy: registered, reflecting state; dsm_en drops on the cycle after the RAMP_DOWN -> IDLE transition.
- enable toggling between slots: only the value sampled on the slot cycle matters.
- Reset mid-operation: immediate return to reset values; the first slot after reset release is R cycles later.

Optional Feature:
Macro DSM_CTRL_UNDERFLOW_CNT_EN.
- Defined: underflow_cnt is implemented as above.
- Undefined: no counter register; underflow_cnt is tied to 0. Hold-last-sample behaviour is unchanged.

Test Plan:
- Reset, R=4, RAMP_SHIFT=2, enable=0: m_tvalid pulses every 4 cycles with tdata 0; tready, dsm_en and underflow_cnt stay 0.
- Constant source 1000, enable=1: outputs 0, 250, 500, 750, then 1000 steady; busy high for 4 slots; dsm_en high from the first slot.
- Source -1000 in RUN: output -1000. During ramp at gain 1 the output is -250 (arithmetic shift).
- enable=0 in RUN: outputs 1000, 750, 500, 250, 0, then IDLE; dsm_en low after; tready stops pulsing.
- tvalid=0 for 3 slots in RUN: output holds last value; underflow_cnt = 3. With the macro undefined: underflow_cnt = 0.
- enable dropped at gain 2 in RAMP_UP: gain goes 2 -> 1 -> 0 with no jump to 4. Reset asserted mid-RUN: all outputs return to 0 immediately.
